multicycle_control: RTL

Parametrised multicycle control sequencer for the RV32I core, replacing the single-cycle opcode decoder when the datapath shares one ALU and talks to instruction and data memories with variable latency. An FSM walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives the same control bus (ALU intent, source selects, enables, halt) plus PC/IR write strobes and memory request handshakes. It sits between the IR/PC registers and the datapath muxes, and adds wait-state handling, a memory timeout, illegal-opcode trapping and a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/opcode_classifier.sv | 20 ++
 rtl/multicycle_control.sv | 110 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, control encodings, FSM states and opcode classes
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RTY = 2'b10;
  localparam logic [1:0] ALU_ITY = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_SYSTEM, C_ILLEGAL
  } cls_t;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps a 7-bit RV32I opcode to its instruction class
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls
);
  // anything not in the supported set (including AUIPC/FENCE) is illegal
  always_comb begin
    cls = opcode == OP_R      ? C_R      :
          opcode == OP_I      ? C_I      :
          opcode == OP_LOAD   ? C_LOAD   :
          opcode == OP_STORE  ? C_STORE  :
          opcode == OP_BRANCH ? C_BRANCH :
          opcode == OP_JAL    ? C_JAL    :
          opcode == OP_JALR   ? C_JALR   :
          opcode == OP_LUI    ? C_LUI    :
          opcode == OP_SYSTEM ? C_SYSTEM : C_ILLEGAL;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with wait states, timeout and retire count
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT        = 15,
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [6:0]       opcode_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             ir_write_en_o,
  output logic             pc_write_en_o,
  output logic [1:0]       pc_src_optn,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             reg_write_en,
  output logic [1:0]       rd_src_optn,
  output logic [1:0]       alu_intent,
  output logic             alu_src_optn,
  output logic             is_halt,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  state_t          state, next;
  cls_t            cls, dec_cls;
  logic [WW-1:0]   wait_cnt;
  logic            illegal, timeout;
  logic [CNT_W-1:0] retired;
  logic            live, waiting, tmo, is_exe, is_mem, is_wb, link, retire, dec_nop;

  opcode_classifier u_cls (.opcode(opcode_i), .cls(dec_cls));

  // strobes are suppressed while reset is asserted so an aborted instruction writes nothing
  assign live    = !rst_i;
  assign waiting = state == S_FETCH || state == S_MEMORY;
  assign tmo     = waiting && !mem_ready_i && wait_cnt == WW'(MAX_WAIT - 1);
  assign is_exe  = state == S_EXECUTE;
  assign is_mem  = state == S_MEMORY;
  assign is_wb   = state == S_WRITEBACK;
  assign link    = cls == C_JAL || cls == C_JALR;
  assign dec_nop = state == S_DECODE && dec_cls == C_ILLEGAL && !HALT_ON_ILLEGAL;
  assign retire  = dec_nop || (is_exe && (cls == C_BRANCH || link)) ||
                   (is_mem && cls == C_STORE && mem_ready_i) || is_wb;

  // next-state selection; timeout wins only when the ack is still missing
  always_comb begin
    next = state;
    case (state)
      S_IDLE:      next = start_i ? S_FETCH : S_IDLE;
      S_FETCH:     next = mem_ready_i ? S_DECODE : tmo ? S_HALT : S_FETCH;
      S_DECODE:    next = dec_cls == C_SYSTEM || (dec_cls == C_ILLEGAL && HALT_ON_ILLEGAL) ? S_HALT :
                          dec_cls == C_ILLEGAL ? S_FETCH : S_EXECUTE;
      S_EXECUTE:   next = cls == C_LOAD || cls == C_STORE ? S_MEMORY :
                          cls == C_R || cls == C_I || cls == C_LUI ? S_WRITEBACK : S_FETCH;
      S_MEMORY:    next = mem_ready_i ? (cls == C_LOAD ? S_WRITEBACK : S_FETCH) : tmo ? S_HALT : S_MEMORY;
      S_WRITEBACK: next = S_FETCH;
      default:     next = state;
    endcase
  end

  // state, latched class, wait counter, sticky causes and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cls      <= C_ILLEGAL;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= next;
      wait_cnt <= (waiting && !mem_ready_i) ? wait_cnt + WW'(1) : '0;
      timeout  <= timeout | tmo;
      if (retire) retired <= retired + CNT_W'(1);
      if (state == S_DECODE) begin
        cls     <= dec_cls;
        illegal <= illegal | (dec_cls == C_ILLEGAL && HALT_ON_ILLEGAL);
      end
    end
  end

  assign imem_req_o    = live && state == S_FETCH;
  assign dmem_req_o    = live && is_mem;
  assign ir_write_en_o = live && state == S_FETCH && mem_ready_i;
  assign pc_write_en_o = live && retire;
  assign mem_read_en   = live && is_mem && cls == C_LOAD;
  assign mem_write_en  = live && is_mem && cls == C_STORE;
  assign reg_write_en  = live && (is_wb || (is_exe && link));
  assign pc_src_optn   = is_exe && (cls == C_JAL || (cls == C_BRANCH && branch_taken_i)) ? PC_IMM :
                         is_exe && cls == C_JALR ? PC_ALU : PC_PLUS4;
  assign rd_src_optn   = is_wb && cls == C_LOAD ? WB_MEM : is_exe && link ? WB_PC4 : WB_ALU;
  assign alu_intent    = !is_exe ? ALU_ADD : cls == C_R ? ALU_RTY : cls == C_I ? ALU_ITY :
                         cls == C_BRANCH ? ALU_SUB : ALU_ADD;
  assign alu_src_optn  = is_exe && (cls == C_I || cls == C_LOAD || cls == C_STORE || cls == C_JALR || cls == C_LUI);
  assign is_halt       = state == S_HALT;
  assign illegal_o     = illegal;
  assign timeout_o     = timeout;
  assign state_o       = state;
  assign retired_o     = retired;
endmodule
